inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage of the RISC-V core; sits directly upstream of the IF/ID pipeline register and feeds it instruction address, instruction word and fetch-exception flag. Owns the fetch PC, drives the instruction bus with at most one outstanding request, buffers returned words in a 2-entry FIFO so one-cycle memories sustain one instruction per cycle under back-pressure, and handles redirects (jump/branch/trap) by flushing and discarding in-flight data. Presents a NOP bubble whenever no fetched instruction is available.

## Interface
- RESET_ADDR, 32'h0000_0000, PC loaded on reset; must be word-aligned
- INST_NOP, 32'h0000_0013, word presented when FIFO empty or entry is an exception
- clk  in  1  core clock, all logic on posedge
- rst_sync_n  in  1  reset, synchronous, active-low
- stall_n  in  1  downstream accepts head entry this cycle when 1
- redirect_valid  in  1  flush and restart fetch at redirect_addr
- redirect_addr  in  32  new fetch PC
- ibus_req  out  1  request valid
- ibus_addr  out  32  word address of request
- ibus_gnt  in  1  request accepted this cycle
- ibus_rvalid  in  1  response valid (≥1 cycle after gnt)
- ibus_rdata  in  32  response word
- ibus_err  in  1  response is a bus error (qualified by rvalid)
- instruction_addr_if  out  32  head entry address; fetch PC when empty
- instruction_if  out  32  head entry word; INST_NOP when empty or exception entry
- exception_if  out  1  head entry is misaligned/bus-error fault
- fetch_bubble  out  1  FIFO empty (output is a bubble)

## Operation
- State: pc[31:0], FIFO (2 × {addr, inst, exc}), count 0..2, outstanding (0/1), kill (0/1), halted (0/1).
- Issue: ibus_req = !halted && (count + outstanding − pop) ≤ 1, or a previously asserted, ungranted request (sticky). pop = stall_n && count≠0. ibus_addr = pc.
- Once asserted, ibus_req and ibus_addr hold stable until ibus_gnt, even across redirect; such a grant is marked kill.
- On gnt: outstanding←1, pc←pc+4 (mod 2^32, wraps FFFF_FFFC→0000_0000).
- On rvalid with outstanding: outstanding←0; if kill, discard and clear kill; else push {request addr, rdata, err}. If err: halted←1.
- rvalid with no outstanding request: ignored.
- Pop and push same cycle: legal, count unchanged.
- Redirect (highest priority): FIFO flushed (count←0), kill←outstanding or granted-this-cycle, halted←0, pc←redirect_addr. No new request issues in the redirect cycle unless a sticky request is pending.
- Misaligned redirect (redirect_addr[1:0]≠0): no bus request; next cycle push {redirect_addr, INST_NOP, exc=1}; halted←1 until next redirect.
- Halted: no new requests; existing FIFO entries still drain.
- Exception entries present instruction_if = INST_NOP, exception_if=1.

## Timing
- Reset (rst_sync_n=0 at edge): pc←RESET_ADDR, count←0, outstanding←0, kill←0, halted←0. Outputs after reset: ibus_req=0 during reset, instruction_if=INST_NOP, exception_if=0, fetch_bubble=1, instruction_addr_if=RESET_ADDR.
- First ibus_req in first cycle with rst_sync_n=1.
- Latency: gnt cycle N, rvalid N+1 → entry visible at outputs N+2; consumed at edge ending N+2 if stall_n.
- Sustained one instruction/cycle with gnt same cycle, rvalid next cycle, stall_n=1.
- FIFO never overflows: issue rule reserves a slot for every outstanding response.
- Redirect output effect: next cycle outputs are bubble (or exception entry one cycle later for misaligned).
- Reset mid-transaction: all state cleared; late rvalid ignored.

## Test plan
- Reset release, zero-wait memory, stall_n=1: addresses 0x0,0x4,0x8… appear on consecutive cycles from cycle 3; fetch_bubble=0 steady.
- stall_n=0 for 5 cycles mid-stream: count reaches 2, ibus_req drops, no word lost or duplicated; stream resumes in order.
- Redirect to 0x100 while request to 0x20 outstanding: 0x20 response discarded, next valid entry addr=0x100.
- Redirect to 0x102: no bus request; one entry addr=0x102, exception_if=1, instruction_if=0x0000_0013; then halted until redirect to 0x200 resumes.
- rvalid with ibus_err=1 for 0x40: entry exception_if=1 at 0x40, no further requests until redirect.
- gnt delayed 3 cycles with redirect during wait: ibus_addr stable until gnt, granted response killed, fetch resumes at redirect target.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one bus request
// outstanding, buffers returned words in a 2-entry FIFO and handles redirects
// by flushing the FIFO and killing any in-flight response.
module inst_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] INST_NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_sync_n,
  input  logic        stall_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  output logic [31:0] instruction_addr_if,
  output logic [31:0] instruction_if,
  output logic        exception_if,
  output logic        fetch_bubble
);

  logic [31:0]      pc;
  logic [1:0][31:0] f_addr;
  logic [1:0][31:0] f_inst;
  logic [1:0]       f_exc;
  logic [1:0]       count;
  logic             outstanding;
  logic             kill;
  logic             halted;
  logic             sticky;     // request shown last cycle, not yet granted
  logic             stale;      // sticky request was overtaken by a redirect
  logic             mis_pend;   // misaligned redirect: push fault entry next cycle
  logic [31:0]      hold_addr;
  logic [31:0]      req_addr;   // address of the granted, in-flight request

  logic        pop;
  logic        push;
  logic [31:0] push_addr;
  logic [31:0] push_inst;
  logic        push_exc;
  logic [2:0]  occ;
  logic        new_req;
  logic        gnt;
  logic        mis_redir;
  logic        out_next;
  logic        wr_idx;
  logic [1:0]  cnt_m_pop;

  // Issue decision, FIFO push source and next outstanding state
  always_comb begin
    pop       = stall_n && (count != 2'd0);
    occ       = {1'b0, count} + {2'b0, outstanding} - {2'b0, pop};
    new_req   = !halted && !redirect_valid && (occ <= 3'd1);
    ibus_req  = rst_sync_n && (sticky || new_req);
    ibus_addr = sticky ? hold_addr : pc;
    gnt       = ibus_req && ibus_gnt;
    mis_redir = redirect_valid && (redirect_addr[1:0] != 2'b00);
    out_next  = gnt ? 1'b1 : (ibus_rvalid ? 1'b0 : outstanding);
    push      = 1'b0;
    push_addr = pc;
    push_inst = INST_NOP;
    push_exc  = 1'b0;
    // Any response arriving while a fault entry is pending is necessarily killed.
    if (mis_pend) begin
      push     = 1'b1;
      push_exc = 1'b1;
    end else if (ibus_rvalid && outstanding && !kill) begin
      push      = 1'b1;
      push_addr = req_addr;
      push_inst = ibus_rdata;
      push_exc  = ibus_err;
    end
    cnt_m_pop = count - {1'b0, pop};
    wr_idx    = cnt_m_pop[0];
  end

  // Fetch state, bus tracking and FIFO storage
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      pc          <= RESET_ADDR;
      count       <= 2'd0;
      outstanding <= 1'b0;
      kill        <= 1'b0;
      halted      <= 1'b0;
      sticky      <= 1'b0;
      stale       <= 1'b0;
      mis_pend    <= 1'b0;
      hold_addr   <= RESET_ADDR;
      req_addr    <= RESET_ADDR;
      f_addr      <= '0;
      f_inst      <= '0;
      f_exc       <= '0;
    end else begin
      sticky      <= ibus_req && !ibus_gnt;
      stale       <= ibus_req && !ibus_gnt && (stale || redirect_valid);
      if (ibus_req && !ibus_gnt) hold_addr <= ibus_addr;
      outstanding <= out_next;
      if (gnt) req_addr <= ibus_addr;
      mis_pend    <= mis_redir;

      if (redirect_valid)                kill <= out_next;
      else if (gnt)                      kill <= stale;
      else if (ibus_rvalid && outstanding) kill <= 1'b0;

      // A stale grant belongs to the old stream and must not advance the PC.
      if (redirect_valid)     pc <= redirect_addr;
      else if (gnt && !stale) pc <= pc + 32'd4;

      if (redirect_valid)         halted <= mis_redir;
      else if (push && push_exc)  halted <= 1'b1;

      if (redirect_valid) begin
        count <= 2'd0;
      end else begin
        if (pop) begin
          f_addr[0] <= f_addr[1];
          f_inst[0] <= f_inst[1];
          f_exc[0]  <= f_exc[1];
        end
        if (push) begin
          f_addr[wr_idx] <= push_addr;
          f_inst[wr_idx] <= push_inst;
          f_exc[wr_idx]  <= push_exc;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // Head-of-FIFO presentation; bubble with current PC when empty
  always_comb begin
    fetch_bubble        = (count == 2'd0);
    instruction_addr_if = fetch_bubble ? pc : f_addr[0];
    exception_if        = !fetch_bubble && f_exc[0];
    instruction_if      = (fetch_bubble || f_exc[0]) ? INST_NOP : f_inst[0];
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a behavioural memory answers requests, and a
// stream-level model predicts the sequence of consumed instructions.
module tb_inst_fetch;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;

  logic        clk = 0;
  logic        rst_sync_n = 0;
  logic        stall_n = 1;
  logic        redirect_valid = 0;
  logic [31:0] redirect_addr = 0;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt = 0;
  logic        ibus_rvalid = 0;
  logic [31:0] ibus_rdata = 0;
  logic        ibus_err = 0;
  logic [31:0] instruction_addr_if;
  logic [31:0] instruction_if;
  logic        exception_if;
  logic        fetch_bubble;

  inst_fetch #(.RESET_ADDR(RESET_ADDR), .INST_NOP(INST_NOP)) dut (
    .clk(clk), .rst_sync_n(rst_sync_n), .stall_n(stall_n),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .ibus_err(ibus_err),
    .instruction_addr_if(instruction_addr_if), .instruction_if(instruction_if),
    .exception_if(exception_if), .fetch_bubble(fetch_bubble));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, n_cons = 0;
  int lat = 1, gnt_wait = 0, held = 0, mem_left = 0;
  int mode = 0;  // 0 stream, 1 fault entry due, 2 one trailing entry allowed, 3 halted
  bit mem_busy = 0, err_en = 0, rnd_err = 0;
  bit prev_redir = 0, prev_ungnt = 0, chk_first = 0, rst_drv = 0;
  logic [31:0] mem_addr = 0, exp_addr = RESET_ADDR, err_at = 0, prev_addr = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return (err_en && a == err_at) || (rnd_err && a[7:2] == 6'h2A);
  endfunction

  task automatic consume();
    logic [31:0] ea, ei;
    logic ee;
    vectors++;
    n_cons++;
    if (mode == 3) begin
      miscompares++;
      $display("FAIL extra_entry: got addr %h inst %h, want no entry", instruction_addr_if, instruction_if);
      return;
    end
    ea = exp_addr;
    if (mode == 1) begin
      ei = INST_NOP; ee = 1'b1; mode = 3;
    end else begin
      ee = is_err(exp_addr);
      ei = ee ? INST_NOP : mem_word(exp_addr);
      mode = (mode == 2) ? 3 : (ee ? 2 : 0);
      exp_addr = exp_addr + 32'd4;
    end
    if (instruction_addr_if !== ea || instruction_if !== ei || exception_if !== ee) begin
      miscompares++;
      $display("FAIL entry: got addr %h inst %h exc %b, want addr %h inst %h exc %b",
               instruction_addr_if, instruction_if, exception_if, ea, ei, ee);
    end
  endtask

  // One clock cycle: drive inputs, act as memory, check, then advance the models.
  task automatic step(input bit stl, input bit rv, input logic [31:0] ra);
    @(negedge clk);
    rst_sync_n = rst_drv;
    stall_n = stl; redirect_valid = rv; redirect_addr = ra;
    ibus_rvalid = mem_busy && mem_left == 0;
    ibus_rdata  = ibus_rvalid ? mem_word(mem_addr) : $urandom;
    ibus_err    = ibus_rvalid ? is_err(mem_addr) : 1'($urandom_range(0, 1));
    ibus_gnt    = 0;
    #1;
    if (!rst_sync_n) begin
      vectors++;
      if (ibus_req !== 1'b0) begin
        miscompares++; $display("FAIL req_in_reset: got %b, want 0", ibus_req);
      end
    end else begin
      if (chk_first) begin
        chk_first = 0; vectors++;
        if (ibus_req !== 1'b1 || ibus_addr !== RESET_ADDR) begin
          miscompares++;
          $display("FAIL first_req: got req %b addr %h, want 1 %h", ibus_req, ibus_addr, RESET_ADDR);
        end
      end
      if (prev_ungnt) begin
        vectors++;
        if (ibus_req !== 1'b1 || ibus_addr !== prev_addr) begin
          miscompares++;
          $display("FAIL req_hold: got req %b addr %h, want 1 %h", ibus_req, ibus_addr, prev_addr);
        end
      end
      if (ibus_req === 1'b1 && (!mem_busy || ibus_rvalid) && held >= gnt_wait) ibus_gnt = 1;
      #1;
      if (prev_redir) begin
        vectors++;
        if (fetch_bubble !== 1'b1) begin
          miscompares++; $display("FAIL redir_bubble: got %b, want 1", fetch_bubble);
        end
      end
      if (!rv && stl && fetch_bubble === 1'b0) consume();
    end
    prev_ungnt = (ibus_req === 1'b1) && !ibus_gnt;
    prev_addr  = ibus_addr;
    prev_redir = rv && rst_sync_n;
    if (prev_ungnt) held++; else held = 0;
    @(posedge clk);
    if (ibus_rvalid) mem_busy = 0;
    else if (mem_busy) mem_left--;
    if (ibus_gnt) begin
      mem_busy = 1; mem_addr = ibus_addr; mem_left = lat - 1;
    end
    if (!rst_sync_n) begin
      exp_addr = RESET_ADDR; mode = 0; prev_ungnt = 0; prev_redir = 0; held = 0;
    end else if (rv) begin
      exp_addr = ra; mode = (ra[1:0] != 2'b00) ? 1 : 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  task automatic check_progress(input string name, input int n0, input int min_new);
    vectors++;
    if (n_cons - n0 < min_new) begin
      miscompares++;
      $display("FAIL %s: got %0d new entries, want >= %0d", name, n_cons - n0, min_new);
    end
  endtask

  task automatic test_reset();
    rst_drv = 0;
    step(1, 0, 0);
    step(1, 0, 0);
    #1;
    vectors++;
    if (instruction_if !== INST_NOP || exception_if !== 1'b0 || fetch_bubble !== 1'b1 ||
        instruction_addr_if !== RESET_ADDR || ibus_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got inst %h exc %b bub %b addr %h req %b, want %h 0 1 %h 0",
               instruction_if, exception_if, fetch_bubble, instruction_addr_if, ibus_req, INST_NOP, RESET_ADDR);
    end
  endtask

  task automatic test_sustained();
    rst_drv = 1; chk_first = 1; lat = 1; gnt_wait = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0);
      if (i >= 2) begin
        #1; vectors++;
        if (fetch_bubble !== 1'b0) begin
          miscompares++; $display("FAIL sustained_bubble: cycle %0d got %b, want 0", i + 1, fetch_bubble);
        end
      end
    end
  endtask

  task automatic test_stall();
    int n0;
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    #1; vectors++;
    if (ibus_req !== 1'b0 || fetch_bubble !== 1'b0) begin
      miscompares++; $display("FAIL stall_full: got req %b bub %b, want 0 0", ibus_req, fetch_bubble);
    end
    n0 = n_cons;
    run(10);
    check_progress("stall_resume", n0, 9);
  endtask

  task automatic test_redirect_outstanding();
    int k = 0, n0;
    lat = 3;
    step(1, 1, 32'h0);
    while (!(mem_busy && mem_addr == 32'h20) && k < 200) begin step(1, 0, 0); k++; end
    vectors++;
    if (k >= 200) begin miscompares++; $display("FAIL wait_0x20: got timeout, want request to 0x20"); end
    step(1, 1, 32'h100);
    n0 = n_cons;
    run(16);
    check_progress("redirect_0x100", n0, 3);
    lat = 1;
    run(6);
  endtask

  task automatic test_misaligned();
    int n0;
    step(1, 1, 32'h102);
    n0 = n_cons;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      #1; vectors++;
      if (ibus_req !== 1'b0) begin
        miscompares++; $display("FAIL misaligned_req: got %b, want 0", ibus_req);
      end
    end
    vectors++;
    if (n_cons - n0 != 1) begin
      miscompares++; $display("FAIL misaligned_count: got %0d entries, want 1", n_cons - n0);
    end
    step(1, 1, 32'h200);
    n0 = n_cons;
    run(8);
    check_progress("resume_0x200", n0, 5);
  endtask

  task automatic test_bus_err();
    int k = 0, n0;
    err_en = 1; err_at = 32'h40;
    step(1, 1, 32'h0);
    while (mode < 2 && k < 60) begin step(1, 0, 0); k++; end
    vectors++;
    if (mode < 2) begin miscompares++; $display("FAIL err_entry: got no fault entry, want fault at 0x40"); end
    run(6);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      #1; vectors++;
      if (ibus_req !== 1'b0) begin
        miscompares++; $display("FAIL err_halt_req: got %b, want 0", ibus_req);
      end
    end
    err_en = 0;
    step(1, 1, 32'h80);
    n0 = n_cons;
    run(8);
    check_progress("resume_0x80", n0, 5);
  endtask

  task automatic test_gnt_delay_redirect();
    int k = 0, n0;
    gnt_wait = 3;
    step(1, 1, 32'h400);
    while (!prev_ungnt && k < 20) begin step(1, 0, 0); k++; end
    vectors++;
    if (!prev_ungnt) begin miscompares++; $display("FAIL wait_sticky: got timeout, want pending request"); end
    step(1, 1, 32'h300);
    n0 = n_cons;
    run(24);
    check_progress("resume_0x300", n0, 3);
    gnt_wait = 0;
    run(4);
  endtask

  task automatic test_wrap();
    int n0;
    step(1, 1, 32'hFFFF_FFF8);
    n0 = n_cons;
    run(10);
    check_progress("wrap", n0, 6);
  endtask

  task automatic test_reset_mid();
    int k = 0, n0;
    lat = 3;
    while (!mem_busy && k < 20) begin step(1, 0, 0); k++; end
    rst_drv = 0;
    step(1, 0, 0);
    rst_drv = 1; chk_first = 1;
    n0 = n_cons;
    run(20);
    check_progress("reset_mid", n0, 3);
    lat = 1;
  endtask

  task automatic test_random();
    bit rv, stl;
    logic [31:0] ra;
    rnd_err = 1;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) gnt_wait = $urandom_range(0, 2);
      lat = $urandom_range(1, 3);
      rv  = ($urandom_range(0, 24) == 0);
      ra  = 32'($urandom_range(0, 1023)) & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      stl = ($urandom_range(0, 3) != 0);
      step(stl, rv, ra);
    end
    rnd_err = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sustained();
    test_stall();
    test_redirect_outstanding();
    test_misaligned();
    test_bus_err();
    test_gnt_delay_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
